// File: rtl/branch_predict_unit_if.sv
// ----------------------------------------------------------------------------
// branch_predict_unit_if
//   Bundles the fetch-side lookup and the MEM-side resolution/update signals
//   of the branch predictor.
//   master : core side. Drives fetch_pc_i and upd_*_i, receives predictions
//            and the flush/redirect request.
//   slave  : predictor side. It is the mirror of master.
//   Signals:
//     fetch_pc_i     PC being fetched this cycle
//     pred_taken_o   predicted taken (combinational)
//     pred_pc_o      predicted next PC (combinational)
//     upd_valid_i    resolved control instruction in MEM this cycle
//     upd_pc_i       PC of the resolved instruction
//     upd_is_jal_i   1 = unconditional jump, 0 = conditional branch
//     upd_taken_i    actual direction
//     upd_target_i   actual target
//     upd_pred_tk_i  direction predicted at IF for this instruction
//     upd_pred_pc_i  next PC predicted at IF for this instruction
//     mispredict_o   flush request (combinational)
//     redirect_pc_o  correct next PC
// ----------------------------------------------------------------------------
interface branch_predict_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] fetch_pc_i;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_pc_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_is_jal_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_pred_tk_i;
  logic [ADDR_W-1:0] upd_pred_pc_i;
  logic              mispredict_o;
  logic [ADDR_W-1:0] redirect_pc_o;

  modport master (
    output fetch_pc_i, upd_valid_i, upd_pc_i, upd_is_jal_i, upd_taken_i,
           upd_target_i, upd_pred_tk_i, upd_pred_pc_i,
    input  pred_taken_o, pred_pc_o, mispredict_o, redirect_pc_o
  );

  modport slave (
    input  fetch_pc_i, upd_valid_i, upd_pc_i, upd_is_jal_i, upd_taken_i,
           upd_target_i, upd_pred_tk_i, upd_pred_pc_i,
    output pred_taken_o, pred_pc_o, mispredict_o, redirect_pc_o
  );
endinterface

// File: rtl/branch_predict_unit.sv
// ----------------------------------------------------------------------------
// branch_predict_unit
//   Dynamic branch predictor. It has a direct-mapped BTB, and each entry holds
//   a saturating direction counter.
//   Lookup is combinational on the fetch PC. Training happens on the clock
//   edge, from the branch resolution that arrives from MEM.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset; clears every table entry
//     bpu   branch_predict_unit_if.slave (lookup, update, mispredict/redirect)
//   Optional feature (macro BPU_STATS_EN):
//     stat_branches_o  saturating count of cycles with a valid update
//     stat_mispred_o   saturating count of cycles with a mispredict
// ----------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_unit_if.slave  bpu
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]           stat_branches_o,
  output logic [31:0]           stat_mispred_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_WEAK = CNT_W'(1 << (CNT_W - 1));
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

  // Table storage. Lookup is zero-latency, so the tables are kept in flops.
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic              jal_q    [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  // --------------------------------------------------------------------------
  // Lookup
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  assign lk_idx = bpu.fetch_pc_i[IDX_W+1:2];
  assign lk_tag = bpu.fetch_pc_i[ADDR_W-1:IDX_W+2];

  // The asynchronous reset already clears valid. The explicit rst term also
  // holds predictions at not-taken for the whole time reset stays low.
  assign lk_hit   = rst & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit & (jal_q[lk_idx] | cnt_q[lk_idx][CNT_W-1]);

  assign bpu.pred_taken_o = lk_taken;
  assign bpu.pred_pc_o    = lk_taken ? target_q[lk_idx]
                                     : bpu.fetch_pc_i + PC_STEP;

  // --------------------------------------------------------------------------
  // Resolution: mispredict / redirect
  // --------------------------------------------------------------------------
  logic upd_en;
  logic dir_wrong;
  logic tgt_wrong;
  logic mispredict;

  assign upd_en    = rst & bpu.upd_valid_i;
  assign dir_wrong = bpu.upd_taken_i != bpu.upd_pred_tk_i;
  // A wrong target matters only when the branch was actually taken. For a
  // not-taken branch, the fall-through path was already fetched.
  assign tgt_wrong = bpu.upd_taken_i & (bpu.upd_target_i != bpu.upd_pred_pc_i);

  assign mispredict        = upd_en & (dir_wrong | tgt_wrong);
  assign bpu.mispredict_o  = mispredict;
  assign bpu.redirect_pc_o = !upd_en          ? '0 :
                             bpu.upd_taken_i  ? bpu.upd_target_i :
                                                bpu.upd_pc_i + PC_STEP;

  // --------------------------------------------------------------------------
  // Training
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CNT_W-1:0] upd_cnt_q;
  logic [CNT_W-1:0] upd_cnt_d;

  assign upd_idx   = bpu.upd_pc_i[IDX_W+1:2];
  assign upd_tag   = bpu.upd_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_hit   = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  assign upd_cnt_q = cnt_q[upd_idx];

  always_comb begin
    upd_cnt_d = upd_cnt_q;
    if (bpu.upd_taken_i) begin
      if (upd_cnt_q != CNT_MAX) upd_cnt_d = upd_cnt_q + 1'b1;
    end else begin
      if (upd_cnt_q != CNT_ZERO) upd_cnt_d = upd_cnt_q - 1'b1;
    end
  end

  // The lookup reads these arrays combinationally. A same-cycle update to
  // the same index therefore becomes visible only on the next cycle, and
  // there is no bypass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jal_q[i]    <= 1'b0;
        cnt_q[i]    <= '0;
      end
    end else if (bpu.upd_valid_i) begin
      if (upd_hit) begin
        cnt_q[upd_idx] <= upd_cnt_d;
        if (bpu.upd_taken_i) begin
          target_q[upd_idx] <= bpu.upd_target_i;
          jal_q[upd_idx]    <= bpu.upd_is_jal_i;
        end
      end else if (bpu.upd_taken_i) begin
        // A taken miss allocates the entry. It evicts whatever aliased there.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= bpu.upd_target_i;
        jal_q[upd_idx]    <= bpu.upd_is_jal_i;
        cnt_q[upd_idx]    <= CNT_WEAK;
      end
    end
  end

`ifdef BPU_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics counters (saturating)
  // --------------------------------------------------------------------------
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (bpu.upd_valid_i && stat_br_q != 32'hFFFF_FFFF) stat_br_q <= stat_br_q + 32'd1;
      if (mispredict && stat_mp_q != 32'hFFFF_FFFF)      stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches_o = stat_br_q;
  assign stat_mispred_o  = stat_mp_q;
`endif

  // The low two PC bits never reach the index or tag, because instructions
  // are word aligned.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bpu.fetch_pc_i[1:0], bpu.upd_pc_i[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_predict_unit_if #(.ADDR_W(32)) bus ();

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  branch_predict_unit #(
    .ADDR_W  (32),
    .ENTRIES (16),
    .CNT_W   (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bpu             (bus.slave)
`ifdef BPU_STATS_EN
    ,
    .stat_branches_o (stat_branches),
    .stat_mispred_o  (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One stimulus step, together with what the bench expects to see for it.
  typedef struct {
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic        jal;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ppc;
    logic        e_tk;
    logic [31:0] e_pc;
    logic        e_mp;
    logic [31:0] e_rd;
  } step_t;

  typedef struct {
    logic        tk;
    logic [31:0] pc;
    logic        mp;
    logic [31:0] rd;
  } exp_t;

  exp_t sb_q[$];

  function automatic step_t mk(logic [31:0] fpc, logic uv, logic [31:0] upc,
                               logic jal, logic tk, logic [31:0] tgt,
                               logic ptk, logic [31:0] ppc,
                               logic e_tk, logic [31:0] e_pc,
                               logic e_mp, logic [31:0] e_rd);
    step_t s;
    s.fpc = fpc; s.uv = uv; s.upc = upc; s.jal = jal; s.tk = tk; s.tgt = tgt;
    s.ptk = ptk; s.ppc = ppc; s.e_tk = e_tk; s.e_pc = e_pc; s.e_mp = e_mp; s.e_rd = e_rd;
    return s;
  endfunction

  // Drive one step just after the falling edge, and queue its expectation.
  task automatic apply(input step_t s);
    exp_t e;
    @(negedge clk);
    bus.fetch_pc_i    = s.fpc;
    bus.upd_valid_i   = s.uv;
    bus.upd_pc_i      = s.upc;
    bus.upd_is_jal_i  = s.jal;
    bus.upd_taken_i   = s.tk;
    bus.upd_target_i  = s.tgt;
    bus.upd_pred_tk_i = s.ptk;
    bus.upd_pred_pc_i = s.ppc;
    e.tk = s.e_tk; e.pc = s.e_pc; e.mp = s.e_mp; e.rd = s.e_rd;
    sb_q.push_back(e);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    step_t s[$];
    exp_t  e;
    // Reset is held low: the update is ignored and outputs stay quiet.
    s.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104,  0, 32'h104, 0, 32'h0));
    // After reset release, with no update.
    s.push_back(mk(32'h100, 0, 32'h100, 0, 0, 32'h0,  0, 32'h0,    0, 32'h104, 0, 32'h0));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      e = sb_q.pop_front();
      $display("test_reset step %0d: fetch=%h tk=%b pc=%h mp=%b rd=%h", i, s[i].fpc,
               bus.pred_taken_o, bus.pred_pc_o, bus.mispredict_o, bus.redirect_pc_o);
      checks++; if (bus.pred_taken_o !== e.tk) begin errors++; $display("FAIL test_reset[%0d] pred_taken got %b want %b", i, bus.pred_taken_o, e.tk); end
      checks++; if (bus.pred_pc_o !== e.pc) begin errors++; $display("FAIL test_reset[%0d] pred_pc got %h want %h", i, bus.pred_pc_o, e.pc); end
      checks++; if (bus.mispredict_o !== e.mp) begin errors++; $display("FAIL test_reset[%0d] mispredict got %b want %b", i, bus.mispredict_o, e.mp); end
      checks++; if (bus.redirect_pc_o !== e.rd) begin errors++; $display("FAIL test_reset[%0d] redirect got %h want %h", i, bus.redirect_pc_o, e.rd); end
`ifdef BPU_STATS_EN
      checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL test_reset[%0d] stat_branches got %0d want 0", i, stat_branches); end
      checks++; if (stat_mispred !== 32'd0) begin errors++; $display("FAIL test_reset[%0d] stat_mispred got %0d want 0", i, stat_mispred); end
`endif
      if (i == 0) begin
        bus.upd_valid_i = 1'b0;
        rst = 1'b1;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_train();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104,  0, 32'h104, 1, 32'h80));
    s.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,    1, 32'h80,  0, 32'h0));
    // Fall-through at the top of the address space wraps to zero.
    s.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0,   0, 32'h0));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      e = sb_q.pop_front();
      $display("test_train step %0d: fetch=%h tk=%b pc=%h mp=%b rd=%h", i, s[i].fpc,
               bus.pred_taken_o, bus.pred_pc_o, bus.mispredict_o, bus.redirect_pc_o);
      checks++; if (bus.pred_taken_o !== e.tk) begin errors++; $display("FAIL test_train[%0d] pred_taken got %b want %b", i, bus.pred_taken_o, e.tk); end
      checks++; if (bus.pred_pc_o !== e.pc) begin errors++; $display("FAIL test_train[%0d] pred_pc got %h want %h", i, bus.pred_pc_o, e.pc); end
      checks++; if (bus.mispredict_o !== e.mp) begin errors++; $display("FAIL test_train[%0d] mispredict got %b want %b", i, bus.mispredict_o, e.mp); end
      checks++; if (bus.redirect_pc_o !== e.rd) begin errors++; $display("FAIL test_train[%0d] redirect got %h want %h", i, bus.redirect_pc_o, e.rd); end
    end
`ifdef BPU_STATS_EN
    checks++; if (stat_branches !== 32'd1) begin errors++; $display("FAIL test_train stat_branches got %0d want 1", stat_branches); end
    checks++; if (stat_mispred !== 32'd1) begin errors++; $display("FAIL test_train stat_mispred got %0d want 1", stat_mispred); end
`endif
  endtask

  // --------------------------------------------------------------------------
  // Counter at 0x100 starts at 2. It is walked down to 0 (and held there),
  // then up to 3 (and held there), then back to 2.
  task automatic test_saturate();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h80, 1, 32'h80,   1, 32'h80,  1, 32'h104));
    s.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h80, 0, 32'h104,  0, 32'h104, 0, 32'h104));
    s.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h80, 0, 32'h104,  0, 32'h104, 0, 32'h104));
    s.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104,  0, 32'h104, 1, 32'h80));
    s.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104,  0, 32'h104, 1, 32'h80));
    s.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80, 1, 32'h80,   1, 32'h80,  0, 32'h80));
    s.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80, 1, 32'h80,   1, 32'h80,  0, 32'h80));
    s.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h80, 1, 32'h80,   1, 32'h80,  1, 32'h104));
    s.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,    1, 32'h80,  0, 32'h0));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      e = sb_q.pop_front();
      $display("test_saturate step %0d: fetch=%h tk=%b pc=%h mp=%b rd=%h", i, s[i].fpc,
               bus.pred_taken_o, bus.pred_pc_o, bus.mispredict_o, bus.redirect_pc_o);
      checks++; if (bus.pred_taken_o !== e.tk) begin errors++; $display("FAIL test_saturate[%0d] pred_taken got %b want %b", i, bus.pred_taken_o, e.tk); end
      checks++; if (bus.pred_pc_o !== e.pc) begin errors++; $display("FAIL test_saturate[%0d] pred_pc got %h want %h", i, bus.pred_pc_o, e.pc); end
      checks++; if (bus.mispredict_o !== e.mp) begin errors++; $display("FAIL test_saturate[%0d] mispredict got %b want %b", i, bus.mispredict_o, e.mp); end
      checks++; if (bus.redirect_pc_o !== e.rd) begin errors++; $display("FAIL test_saturate[%0d] redirect got %h want %h", i, bus.redirect_pc_o, e.rd); end
    end
  endtask

  // --------------------------------------------------------------------------
  // A JAL at 0x200 shares index 0 with 0x100 and evicts it. Counter
  // decrements do not stop it from predicting taken.
  task automatic test_jal();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(32'h200, 1, 32'h200, 1, 1, 32'h400, 0, 32'h204, 0, 32'h204, 1, 32'h400));
    s.push_back(mk(32'h200, 1, 32'h200, 1, 0, 32'h400, 1, 32'h400, 1, 32'h400, 1, 32'h204));
    s.push_back(mk(32'h200, 1, 32'h200, 1, 0, 32'h400, 1, 32'h400, 1, 32'h400, 1, 32'h204));
    s.push_back(mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h400, 0, 32'h0));
    s.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      e = sb_q.pop_front();
      $display("test_jal step %0d: fetch=%h tk=%b pc=%h mp=%b rd=%h", i, s[i].fpc,
               bus.pred_taken_o, bus.pred_pc_o, bus.mispredict_o, bus.redirect_pc_o);
      checks++; if (bus.pred_taken_o !== e.tk) begin errors++; $display("FAIL test_jal[%0d] pred_taken got %b want %b", i, bus.pred_taken_o, e.tk); end
      checks++; if (bus.pred_pc_o !== e.pc) begin errors++; $display("FAIL test_jal[%0d] pred_pc got %h want %h", i, bus.pred_pc_o, e.pc); end
      checks++; if (bus.mispredict_o !== e.mp) begin errors++; $display("FAIL test_jal[%0d] mispredict got %b want %b", i, bus.mispredict_o, e.mp); end
      checks++; if (bus.redirect_pc_o !== e.rd) begin errors++; $display("FAIL test_jal[%0d] redirect got %h want %h", i, bus.redirect_pc_o, e.rd); end
    end
  endtask

  // --------------------------------------------------------------------------
  // Aliasing at index 0, a same-cycle lookup/update without a bypass, a
  // mispredict caused only by the target, and a redirect that wraps.
  task automatic test_alias();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
    s.push_back(mk(32'h100, 1, 32'h140, 0, 1, 32'h300, 0, 32'h144, 1, 32'h80,  1, 32'h300));
    s.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0));
    s.push_back(mk(32'h140, 1, 32'h140, 0, 1, 32'h500, 1, 32'h300, 1, 32'h300, 1, 32'h500));
    s.push_back(mk(32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h500, 0, 32'h0));
    s.push_back(mk(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 32'h10, 1, 32'h10, 0, 32'h0, 1, 32'h0));
    s.push_back(mk(32'h140, 1, 32'h140, 0, 1, 32'h500, 1, 32'h500, 1, 32'h500, 0, 32'h500));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      e = sb_q.pop_front();
      $display("test_alias step %0d: fetch=%h tk=%b pc=%h mp=%b rd=%h", i, s[i].fpc,
               bus.pred_taken_o, bus.pred_pc_o, bus.mispredict_o, bus.redirect_pc_o);
      checks++; if (bus.pred_taken_o !== e.tk) begin errors++; $display("FAIL test_alias[%0d] pred_taken got %b want %b", i, bus.pred_taken_o, e.tk); end
      checks++; if (bus.pred_pc_o !== e.pc) begin errors++; $display("FAIL test_alias[%0d] pred_pc got %h want %h", i, bus.pred_pc_o, e.pc); end
      checks++; if (bus.mispredict_o !== e.mp) begin errors++; $display("FAIL test_alias[%0d] mispredict got %b want %b", i, bus.mispredict_o, e.mp); end
      checks++; if (bus.redirect_pc_o !== e.rd) begin errors++; $display("FAIL test_alias[%0d] redirect got %h want %h", i, bus.redirect_pc_o, e.rd); end
    end
  endtask

  // --------------------------------------------------------------------------
  // Reset is asserted mid-run. Predictions drop while it is low, and the
  // tables stay empty after it is released.
  task automatic test_reset_mid();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(32'h140, 0, 32'h0,   0, 0, 32'h0, 0, 32'h0,   1, 32'h500, 0, 32'h0));
    s.push_back(mk(32'h140, 1, 32'h140, 0, 0, 32'h0, 1, 32'h500, 0, 32'h144, 0, 32'h0));
    s.push_back(mk(32'h140, 0, 32'h0,   0, 0, 32'h0, 0, 32'h0,   0, 32'h144, 0, 32'h0));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      e = sb_q.pop_front();
      $display("test_reset_mid step %0d: fetch=%h tk=%b pc=%h mp=%b rd=%h", i, s[i].fpc,
               bus.pred_taken_o, bus.pred_pc_o, bus.mispredict_o, bus.redirect_pc_o);
      checks++; if (bus.pred_taken_o !== e.tk) begin errors++; $display("FAIL test_reset_mid[%0d] pred_taken got %b want %b", i, bus.pred_taken_o, e.tk); end
      checks++; if (bus.pred_pc_o !== e.pc) begin errors++; $display("FAIL test_reset_mid[%0d] pred_pc got %h want %h", i, bus.pred_pc_o, e.pc); end
      checks++; if (bus.mispredict_o !== e.mp) begin errors++; $display("FAIL test_reset_mid[%0d] mispredict got %b want %b", i, bus.mispredict_o, e.mp); end
      checks++; if (bus.redirect_pc_o !== e.rd) begin errors++; $display("FAIL test_reset_mid[%0d] redirect got %h want %h", i, bus.redirect_pc_o, e.rd); end
      if (i == 0) rst = 1'b0;
      if (i == 1) begin
`ifdef BPU_STATS_EN
        checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL test_reset_mid stat_branches got %0d want 0", stat_branches); end
        checks++; if (stat_mispred !== 32'd0) begin errors++; $display("FAIL test_reset_mid stat_mispred got %0d want 0", stat_mispred); end
`endif
        bus.upd_valid_i = 1'b0;
        rst = 1'b1;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.fetch_pc_i    = '0;
    bus.upd_valid_i   = 1'b0;
    bus.upd_pc_i      = '0;
    bus.upd_is_jal_i  = 1'b0;
    bus.upd_taken_i   = 1'b0;
    bus.upd_target_i  = '0;
    bus.upd_pred_tk_i = 1'b0;
    bus.upd_pred_pc_i = '0;
    repeat (2) @(posedge clk);

    test_reset();
    test_train();
    test_saturate();
    test_jal();
    test_alias();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timeout");
  end

endmodule
